// File: rtl/rr_read_sched_if.sv
// Requester/bus bundle for the round-robin read scheduler.
//   master : scheduler view (drives grants, completion and the bus strobes)
//   slave  : environment view (drives requests, addresses, ws and bus data)
// Signals:
//   req/req_addr    per-requester level request and flattened addresses
//   gnt/done/err    one-hot grant, one-cycle done pulse, timeout error flag
//   rdata           read data, valid while done is high
//   bus_addr/rd/ds  bus address, read strobe, data strobe
//   ws/bus_rdata    bus wait-state and read data
interface rr_read_sched_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      bus_addr;
  logic               rd;
  logic               ds;
  logic               ws;
  logic [DW-1:0]      bus_rdata;

  modport master (
    input  req, req_addr, ws, bus_rdata,
    output gnt, done, err, rdata, bus_addr, rd, ds
  );

  modport slave (
    output req, req_addr, ws, bus_rdata,
    input  gnt, done, err, rdata, bus_addr, rd, ds
  );
endinterface

// File: rtl/rr_read_sched.sv
// Round-robin scheduler sharing one wait-state read bus among NREQ requesters.
// Picks the first pending request at or above ptr (wrapping), latches its index
// and address, runs READ/DLY cycles until ws=0 (DONE) or until TO_CYC
// consecutive ws=1 DLY cycles have been seen (ABORT), then pulses done.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_read_sched_if.master (requester side and bus side)
module rr_read_sched #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int TO_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_read_sched_if.master      bus
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [WCW-1:0] WC_MAX = WCW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DLY   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q,   ptr_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [WCW-1:0]  wcnt_q,  wcnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [IW:0]     pick;       // {valid, index}
  logic [IW-1:0]   next_ptr;

  // First set request bit scanning upward from p, wrapping at NREQ.
  // Scanning from the far end down lets the nearest hit overwrite later ones.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [IW-1:0]   p);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NREQ) j = j - NREQ;
      if (r[j]) res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  assign pick     = rr_pick(bus.req, ptr_q);
  assign next_ptr = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: every next-state variable gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick[IW]) begin
          idx_d   = pick[IW-1:0];
          addr_d  = bus.req_addr[pick[IW-1:0]*AW +: AW];
          wcnt_d  = '0;
          state_d = READ;
        end
      end
      READ: state_d = DLY;
      DLY: begin
        if (!bus.ws) begin
          rdata_d = bus.bus_rdata;
          state_d = DONE;
        end else if (wcnt_q == WC_MAX) begin
          // Counter stops here; the abort path ends the transaction instead.
          state_d = ABORT;
        end else begin
          wcnt_d  = wcnt_q + WCW'(1);
          state_d = READ;
        end
      end
      DONE, ABORT: begin
        ptr_d   = next_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, index, address and data.
  logic [NREQ-1:0] gnt_c, done_c;
  logic [AW-1:0]   bus_addr_c;
  logic [DW-1:0]   rdata_c;
  logic            err_c;

  always_comb begin
    gnt_c      = '0;
    done_c     = '0;
    bus_addr_c = '0;
    rdata_c    = '0;
    err_c      = 1'b0;
    if (state_q != IDLE) begin
      gnt_c[idx_q] = 1'b1;
      bus_addr_c   = addr_q;
    end
    if (state_q == DONE) begin
      done_c[idx_q] = 1'b1;
      rdata_c       = rdata_q;
    end
    if (state_q == ABORT) begin
      done_c[idx_q] = 1'b1;
      err_c         = 1'b1;
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.done     = done_c;
  assign bus.err      = err_c;
  assign bus.rdata    = rdata_c;
  assign bus.bus_addr = bus_addr_c;
  assign bus.rd       = (state_q == READ);
  assign bus.ds       = (state_q == DONE);

endmodule

// File: tb/tb_rr_read_sched.sv
// Directed bench for rr_read_sched (NREQ=4, AW=8, DW=8, TO_CYC=3).
// Each table row is one clock cycle: inputs driven after the falling edge,
// outputs compared 1 time unit later (state-decoded outputs are stable then).
module tb_rr_read_sched;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  rr_read_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif ();

  rr_read_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .TO_CYC(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] addr;
    logic        ws;
    logic [7:0]  brd;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic [7:0]  baddr;
    logic        rd;
    logic        ds;
  } vec_t;

  function automatic vec_t v(logic r, logic [3:0] rq, logic [31:0] a, logic w,
                             logic [7:0] brd, logic [3:0] g, logic [3:0] d,
                             logic e, logic [7:0] rdat, logic [7:0] ba,
                             logic rdv, logic dsv);
    vec_t x;
    x.rst_n = r;   x.req = rq;    x.addr = a;      x.ws = w;   x.brd = brd;
    x.gnt   = g;   x.done = d;    x.err = e;       x.rdata = rdat;
    x.baddr = ba;  x.rd = rdv;    x.ds = dsv;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a3=9C a2=77 a1=4E a0=3C ; B changes a1 to E1 mid-transaction
  localparam logic [31:0] A = 32'h9C77_4E3C;
  localparam logic [31:0] B = 32'h9C77_E13C;

  vec_t tbl[$];

  initial begin
    int got;
    int cyc;
    int prev;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    bif.req = '0; bif.req_addr = A; bif.ws = 1'b0; bif.bus_rdata = '0;
    #1 rst_n = 1'b0;

    //         rst req     addr ws brd  | gnt    done   err rdata baddr rd ds
    // reset state, req ignored while in reset
    tbl.push_back(v(0, 4'b0001, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(0, 4'b0001, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    // single req0, no wait states; ws=1 in READ is a don't-care
    tbl.push_back(v(1, 4'b0001, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b0001, A, 1, 8'h00, 4'b0001, 4'b0000, 0, 8'h00, 8'h3C, 1, 0));
    tbl.push_back(v(1, 4'b0001, A, 0, 8'hA5, 4'b0001, 4'b0000, 0, 8'h00, 8'h3C, 0, 0));
    tbl.push_back(v(1, 4'b0001, A, 0, 8'h00, 4'b0001, 4'b0001, 0, 8'hA5, 8'h3C, 0, 1));
    // req2 with two ws=1 DLY cycles (ptr=1 scan reaches 2)
    tbl.push_back(v(1, 4'b0100, A, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 0, 8'h00, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 1, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'h00, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 0, 8'h00, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 1, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'h00, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 0, 8'h00, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 1, 0));
    tbl.push_back(v(1, 4'b0100, A, 0, 8'h5A, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 0, 8'h00, 4'b0100, 4'b0100, 0, 8'h5A, 8'h77, 0, 1));
    // reset, then all four held: order 0,1,2,3,0
    tbl.push_back(v(0, 4'b1111, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'h00, 8'h3C, 1, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h11, 4'b0001, 4'b0000, 0, 8'h00, 8'h3C, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0001, 4'b0001, 0, 8'h11, 8'h3C, 0, 1));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0010, 4'b0000, 0, 8'h00, 8'h4E, 1, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h22, 4'b0010, 4'b0000, 0, 8'h00, 8'h4E, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0010, 4'b0010, 0, 8'h22, 8'h4E, 0, 1));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 1, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h33, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0100, 4'b0100, 0, 8'h33, 8'h77, 0, 1));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b1000, 4'b0000, 0, 8'h00, 8'h9C, 1, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h44, 4'b1000, 4'b0000, 0, 8'h00, 8'h9C, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b1000, 4'b1000, 0, 8'h44, 8'h9C, 0, 1));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'h00, 8'h3C, 1, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h55, 4'b0001, 4'b0000, 0, 8'h00, 8'h3C, 0, 0));
    tbl.push_back(v(1, 4'b1111, A, 0, 8'h00, 4'b0001, 4'b0001, 0, 8'h55, 8'h3C, 0, 1));
    // req2 with ws stuck high: three DLY cycles, then ABORT (ptr 1 -> grant 2)
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 1, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 1, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 1, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0100, 4'b0000, 0, 8'h00, 8'h77, 0, 0));
    tbl.push_back(v(1, 4'b0100, A, 1, 8'hEE, 4'b0100, 4'b0100, 1, 8'h00, 8'h77, 0, 0));
    // next requester after abort: ptr=3, scan 3 then wraps to 0
    tbl.push_back(v(1, 4'b0011, A, 1, 8'hEE, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b0011, A, 1, 8'hEE, 4'b0001, 4'b0000, 0, 8'h00, 8'h3C, 1, 0));
    // reset while in DLY with ws=1: outputs drop at once, no done pulse
    tbl.push_back(v(0, 4'b0011, A, 1, 8'hEE, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(0, 4'b1010, A, 1, 8'hEE, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    // req1 and req3 pending: ptr back at 0, so 1 is reached before 3
    tbl.push_back(v(1, 4'b1010, A, 1, 8'hEE, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1010, A, 1, 8'hEE, 4'b0010, 4'b0000, 0, 8'h00, 8'h4E, 1, 0));
    // req1 dropped and addr1 changed in DLY: address stays frozen, done still pulses
    tbl.push_back(v(1, 4'b1000, B, 0, 8'hC3, 4'b0010, 4'b0000, 0, 8'h00, 8'h4E, 0, 0));
    tbl.push_back(v(1, 4'b1000, B, 0, 8'h00, 4'b0010, 4'b0010, 0, 8'hC3, 8'h4E, 0, 1));
    // req3 waited while busy, served next
    tbl.push_back(v(1, 4'b1000, B, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b1000, B, 0, 8'h00, 4'b1000, 4'b0000, 0, 8'h00, 8'h9C, 1, 0));
    tbl.push_back(v(1, 4'b1000, B, 0, 8'h3D, 4'b1000, 4'b0000, 0, 8'h00, 8'h9C, 0, 0));
    tbl.push_back(v(1, 4'b1000, B, 0, 8'h00, 4'b1000, 4'b1000, 0, 8'h3D, 8'h9C, 0, 1));
    tbl.push_back(v(1, 4'b0000, B, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(v(1, 4'b0000, B, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n         = tbl[i].rst_n;
      bif.req       = tbl[i].req;
      bif.req_addr  = tbl[i].addr;
      bif.ws        = tbl[i].ws;
      bif.bus_rdata = tbl[i].brd;
      #1;
      check($sformatf("v%0d.gnt", i),      32'(bif.gnt),      32'(tbl[i].gnt));
      check($sformatf("v%0d.done", i),     32'(bif.done),     32'(tbl[i].done));
      check($sformatf("v%0d.err", i),      32'(bif.err),      32'(tbl[i].err));
      check($sformatf("v%0d.rdata", i),    32'(bif.rdata),    32'(tbl[i].rdata));
      check($sformatf("v%0d.bus_addr", i), 32'(bif.bus_addr), 32'(tbl[i].baddr));
      check($sformatf("v%0d.rd", i),       32'(bif.rd),       32'(tbl[i].rd));
      check($sformatf("v%0d.ds", i),       32'(bif.ds),       32'(tbl[i].ds));
    end

    // Single persistent requester: regranted after one IDLE cycle each time,
    // so consecutive done pulses are 4 cycles apart.
    @(negedge clk);
    bif.req       = 4'b0100;
    bif.ws        = 1'b0;
    bif.bus_rdata = 8'h66;
    cyc  = 0;
    prev = 0;
    for (int t = 0; t < 3; t++) begin
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(negedge clk);
        #1;
        cyc++;
        if (bif.done != 4'b0000) got = 1;
      end
      check($sformatf("persist%0d.done_seen", t), 32'(got), 32'd1);
      check($sformatf("persist%0d.done", t), 32'(bif.done), 32'h4);
      check($sformatf("persist%0d.rdata", t), 32'(bif.rdata), 32'h66);
      if (t > 0) check($sformatf("persist%0d.gap", t), 32'(cyc - prev), 32'd4);
      prev = cyc;
      @(negedge clk);
      #1;
      cyc++;
      check($sformatf("persist%0d.idle_gnt", t), 32'(bif.gnt), 32'h0);
    end
    bif.req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_read_sched.md
Name: rr_read_sched

Overview:
- Round-robin scheduler that shares one wait-state read bus among NREQ requesters.
- Arbitrates among pending requests and latches the winner's address.
- Sequences the bus through a READ/DLY/DONE handshake, honouring ws (wait-state) cycles.
- Returns read data and a per-requester done pulse. A wait-state timeout aborts stalled reads with an error flag.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 8, address width
- DW, 8, data width
- TO_CYC, 15, max consecutive ws=1 DLY cycles before abort (1..255)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester read request, level, held until own done
- req_addr  input  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]
- gnt  output  NREQ  one-hot grant for the active transaction
- done  output  NREQ  one-cycle completion pulse to the granted requester
- err  output  1  high with done when the transaction aborted on timeout
- rdata  output  DW  read data, valid while done is high
- bus_addr  output  AW  address to the bus
- rd  output  1  read strobe
- ds  output  1  data strobe (completion)
- ws  input  1  wait-state from the bus, sampled in DLY
- bus_rdata  input  DW  bus data, valid in the DLY cycle where ws=0

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; ptr=0; wcnt=0; idx=0.
  - gnt, done, err, rd, ds, bus_addr and rdata all go to 0.
- States: IDLE, READ, DLY, DONE, ABORT. All outputs are decoded from registered state and idx only.
- IDLE:
  - If any req bit is high, pick the first set bit scanning from ptr upward, modulo NREQ.
  - Latch its index into idx and its address into addr_q, clear wcnt, go to READ.
  - Otherwise stay in IDLE.
  - In IDLE: gnt=0, bus_addr=0.
- READ: rd=1. Always go to DLY next.
- DLY (rd=0, ds=0):
  - ws=0: capture bus_rdata into rdata_q, go to DONE.
  - ws=1 and wcnt < TO_CYC-1: increment wcnt, go back to READ (rd re-strobed).
  - ws=1 and wcnt == TO_CYC-1: go to ABORT.
- DONE: ds=1, done[idx]=1, err=0, rdata=rdata_q. Go to IDLE; ptr <= (idx+1) mod NREQ.
- ABORT: done[idx]=1, err=1, rdata=0. Go to IDLE; ptr <= (idx+1) mod NREQ.
- Grant and bus outputs:
  - gnt[idx]=1 and bus_addr=addr_q from READ through DONE/ABORT inclusive.
  - rdata=0 whenever done is low.
- Latency: a req sampled in IDLE at edge n gives READ at n+1, DLY at n+2, DONE at n+3 (with zero wait-states).
  - Each ws=1 DLY cycle adds 2 cycles (READ+DLY).
  - Every transaction passes through at least one IDLE cycle.
- Requester contract: deassert req on the edge after done. The scheduler never regrants inside the done cycle.
- Boundary cases:
  - req changes, or req_addr changes, during a transaction: ignored; addr_q and idx are frozen.
  - The granted req drops mid-transaction: the transaction still completes and done still pulses.
  - Requests arriving while busy wait for IDLE.
  - ptr wraps from NREQ-1 to 0.
  - A single persistent requester is regranted after each IDLE cycle.
  - ws is a don't-care outside DLY.
  - Reset mid-transaction: immediate return to IDLE with all outputs 0, no done pulse, ptr=0.
  - wcnt saturates at TO_CYC-1; it never wraps.

Test Plan:
- Single req[0]=1, req_addr0=0x3C, ws=0, bus_rdata=0xA5 in DLY -> rd high cycle 1, done[0]=1 and rdata=0xA5 and ds=1 at cycle 3; gnt=0001 for cycles 1-3; err=0.
- req[2]=1, ws=1 for 2 DLY cycles then 0 -> rd pulses 3 times, bus_addr constant; done[2] at cycle 7; err=0.
- All four requesters held high, ws=0 -> grant order 0,1,2,3,0; each done 4 cycles apart; ptr wraps correctly.
- ws stuck at 1, TO_CYC=3 -> three DLY cycles, then ABORT: done[idx]=1, err=1, rdata=0; next requester granted afterwards.
- rst_n pulsed low during DLY with ws=1 -> all outputs 0 immediately; after release, req[1] only is granted first (ptr=0 scan reaches 1).
- req[1] dropped, and req_addr1 changed, while in DLY -> transaction completes with the original address; done[1] still pulses.
